uart_echo_tester: RTL and testbench

Self-checking UART initiator: the opposite end of the byte mirror. It sends an incrementing byte sequence through the existing `uart_tx` handshake and waits for each byte to come back through `uart_rx`. Each returned byte is compared with what was sent, and the block keeps pass, error and timeout counters plus LED indications. It sits in a board top between a `uart_tx`/`uart_rx` pair running on the same clock. That top is then connected to a board or host running the mirror.

---
 rtl/uart_echo_tester_if.sv | 20 ++
 rtl/uart_echo_tester.sv | 163 ++++++++++++++++
 tb/tb_uart_echo_tester.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_echo_tester_if.sv
// Handshake bundle between the echo tester and its uart_tx/uart_rx pair.
// master: the tester (drives send requests, consumes busy and received bytes).
// slave:  the UART side (or a bench model standing in for it).
interface uart_echo_tester_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       rx_ready;
    logic [7:0] rx_data;

    modport master (
        output tx_start, tx_data,
        input  tx_busy, rx_ready, rx_data
    );

    modport slave (
        input  tx_start, tx_data,
        output tx_busy, rx_ready, rx_data
    );
endinterface

// File: rtl/uart_echo_tester.sv
// UART echo tester: sends an incrementing byte sequence through uart_tx,
// waits for each byte to come back on uart_rx, and keeps saturating
// pass / error / timeout counters plus two status LEDs.
module uart_echo_tester #(
    parameter int unsigned CLK_FREQ       = 42_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 42_000,
    parameter int unsigned GAP_CYCLES     = 420,
    parameter logic [7:0]  SEED           = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    uart_echo_tester_if.master        uart,
    output logic [15:0]               pass_count,
    output logic [15:0]               err_count,
    output logic [15:0]               timeout_count,
    output logic [7:0]                last_err_data,
    output logic                      led_ok,
    output logic                      led_err
);

    localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    // CLK_FREQ only documents the intended clock; cycle counts are used directly.
    if (CLK_FREQ == 0) begin : g_clk_freq_unset
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IDLE,
        START,
        WAIT_ECHO,
        GAP
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  seq;
    logic [23:0] timer;
    logic [15:0] gap_cnt;

    logic load_tx;      // WAIT_IDLE saw the transmitter free
    logic drop_tx;      // START saw the transmitter accept the byte
    logic echo_done;    // WAIT_ECHO resolved (echo or timeout)
    logic pass_hit;
    logic err_hit;      // mismatched echo or a stray byte in any other state
    logic timeout_hit;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic and per-cycle event strobes.
    always_comb begin
        state_nxt   = state;
        load_tx     = 1'b0;
        drop_tx     = 1'b0;
        echo_done   = 1'b0;
        pass_hit    = 1'b0;
        err_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (enable) state_nxt = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (!enable) begin
                    state_nxt = IDLE;
                end else if (!uart.tx_busy) begin
                    load_tx   = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                // enable is deliberately ignored: a request is never abandoned.
                if (uart.tx_busy) begin
                    drop_tx   = 1'b1;
                    state_nxt = WAIT_ECHO;
                end
            end
            WAIT_ECHO: begin
                // An echo on the timeout cycle wins over the timeout.
                if (uart.rx_ready) begin
                    echo_done = 1'b1;
                    pass_hit  = (uart.rx_data == seq);
                    err_hit   = (uart.rx_data != seq);
                    state_nxt = GAP;
                end else if (timer == TMO_LAST) begin
                    echo_done   = 1'b1;
                    timeout_hit = 1'b1;
                    state_nxt   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = enable ? WAIT_IDLE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Bytes arriving outside WAIT_ECHO are strays; the FSM ignores them.
        if (state != WAIT_ECHO && uart.rx_ready) err_hit = 1'b1;
    end

    // Send request, sequence byte and the echo / gap timers.
    always_ff @(posedge clk) begin
        if (rst) begin
            uart.tx_start <= 1'b0;
            uart.tx_data  <= 8'h00;
            seq           <= SEED;
            timer         <= '0;
            gap_cnt       <= '0;
        end else begin
            if (load_tx) begin
                uart.tx_data  <= seq;
                uart.tx_start <= 1'b1;
            end
            if (drop_tx) begin
                uart.tx_start <= 1'b0;
                timer         <= '0;
            end else if (state == WAIT_ECHO) begin
                timer <= timer + 24'd1;
            end
            if (echo_done) begin
                seq     <= seq + 8'd1;
                gap_cnt <= '0;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt + 16'd1;
            end
        end
    end

    // Result counters and LEDs, updated the cycle after each outcome.
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_count    <= '0;
            err_count     <= '0;
            timeout_count <= '0;
            last_err_data <= 8'h00;
            led_ok        <= 1'b0;
            led_err       <= 1'b0;
        end else begin
            if (pass_hit) begin
                pass_count <= sat_inc(pass_count);
                led_ok     <= ~led_ok;
            end
            if (err_hit) begin
                err_count     <= sat_inc(err_count);
                last_err_data <= uart.rx_data;
                led_err       <= 1'b1;
            end
            if (timeout_hit) begin
                timeout_count <= sat_inc(timeout_count);
                led_err       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_echo_tester.sv
// Bench for uart_echo_tester: directed vector table, hand-written corner
// sequences (stray bytes, busy before first send, reset mid-transaction) and
// a randomized loopback run scored against a counting model.
`timescale 1ns/1ps
module tb_uart_echo_tester;

    localparam int unsigned TMO        = 1000;
    localparam int unsigned GAP        = 16;
    localparam logic [7:0]  SEED       = 8'h00;
    localparam int          WAIT_LIMIT = 4000;

    localparam int M_ECHO = 0;  // echo the byte back unchanged
    localparam int M_XOR  = 1;  // echo the byte with some bits flipped
    localparam int M_NONE = 2;  // never echo

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] pass_count, err_count, timeout_count;
    logic [7:0]  last_err_data;
    logic        led_ok, led_err;

    uart_echo_tester_if uart();

    uart_echo_tester #(
        .CLK_FREQ      (42_000_000),
        .TIMEOUT_CYCLES(TMO),
        .GAP_CYCLES    (GAP),
        .SEED          (SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .uart         (uart),
        .pass_count   (pass_count),
        .err_count    (err_count),
        .timeout_count(timeout_count),
        .last_err_data(last_err_data),
        .led_ok       (led_ok),
        .led_err      (led_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    // Reference model: outcome counts since the last reset.
    int         m_sent, m_pass, m_err, m_to;
    logic [7:0] m_last;

    typedef struct {
        int          busy;
        int          lat;
        int          mode;
        logic [7:0]  exp_tx;
        logic [15:0] exp_pass;
        logic [15:0] exp_err;
        logic [15:0] exp_to;
        logic [7:0]  exp_last;
        logic        exp_ok;
        logic        exp_lerr;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sent = 0; m_pass = 0; m_err = 0; m_to = 0; m_last = 8'h00;
    endtask

    function automatic logic [7:0] model_byte();
        return SEED + 8'(m_sent);
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".pass"},    32'(pass_count),    32'(m_pass));
        chk({tag, ".err"},     32'(err_count),     32'(m_err));
        chk({tag, ".timeout"}, 32'(timeout_count), 32'(m_to));
        chk({tag, ".last"},    32'(last_err_data), 32'(m_last));
        chk({tag, ".led_ok"},  32'(led_ok),        32'(m_pass % 2));
        chk({tag, ".led_err"}, 32'(led_err),       32'((m_err + m_to) != 0));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        uart.tx_busy = 1'b0;
        uart.rx_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic pulse_rx(input logic [7:0] val);
        uart.rx_data  = val;
        uart.rx_ready = 1'b1;
        @(negedge clk);
        uart.rx_ready = 1'b0;
    endtask

    // Plays the UART pair for one transaction: wait for a request, stay busy
    // for b cycles, then echo l cycles after busy falls (or not at all).
    task automatic serve(input int b, input int l, input int mode, input logic [7:0] xr,
                         input logic [7:0] exp_tx, output logic [7:0] sent);
        int n;
        n = 0;
        sent = 8'h00;
        while (uart.tx_start !== 1'b1 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (uart.tx_start !== 1'b1) begin
            chk("tx_start_wait", 32'(uart.tx_start), 32'd1);
            return;
        end
        sent = uart.tx_data;
        chk("tx_data", 32'(uart.tx_data), 32'(exp_tx));
        uart.tx_busy = 1'b1;
        @(negedge clk);
        chk("tx_start_drop", 32'(uart.tx_start), 32'd0);
        repeat (b - 1) @(negedge clk);
        uart.tx_busy = 1'b0;
        repeat (l) @(negedge clk);
        if (mode == M_ECHO)     pulse_rx(sent);
        else if (mode == M_XOR) pulse_rx(sent ^ xr);
        else                    repeat (TMO + 2) @(negedge clk);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] sent;
        logic       flag;
        int         n;

        // busy, lat, mode, tx byte, pass, err, timeout, last, led_ok, led_err
        vecs[0] = '{3,   2,   M_ECHO, 8'h00, 16'd1, 16'd0, 16'd0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{5,   0,   M_ECHO, 8'h01, 16'd2, 16'd0, 16'd0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{4,   7,   M_XOR,  8'h02, 16'd2, 16'd1, 16'd0, 8'h03, 1'b0, 1'b1};
        vecs[3] = '{2,   1,   M_ECHO, 8'h03, 16'd3, 16'd1, 16'd0, 8'h03, 1'b1, 1'b1};
        // echo lands on the timeout cycle: counts as a pass
        vecs[4] = '{600, 400, M_ECHO, 8'h04, 16'd4, 16'd1, 16'd0, 8'h03, 1'b0, 1'b1};
        vecs[5] = '{10,  0,   M_NONE, 8'h05, 16'd4, 16'd1, 16'd1, 8'h03, 1'b0, 1'b1};
        // echo one cycle after the timeout: timeout plus a stray in GAP
        vecs[6] = '{600, 401, M_ECHO, 8'h06, 16'd4, 16'd2, 16'd2, 8'h06, 1'b0, 1'b1};
        vecs[7] = '{1,   0,   M_ECHO, 8'h07, 16'd5, 16'd2, 16'd2, 8'h06, 1'b1, 1'b1};

        uart.rx_data = 8'h00;
        do_reset();

        // Reset state.
        chk("rst.tx_start", 32'(uart.tx_start), 32'd0);
        chk("rst.tx_data",  32'(uart.tx_data),  32'd0);
        check_model("rst");

        // Idle with enable low: no request.
        repeat (20) @(negedge clk);
        chk("idle.tx_start", 32'(uart.tx_start), 32'd0);

        // Stray byte in IDLE.
        pulse_rx(8'hAA);
        m_err++; m_last = 8'hAA;
        check_model("stray_idle");

        // Transmitter busy for 500 cycles before the first send.
        uart.tx_busy = 1'b1;
        enable = 1'b1;
        flag = 1'b1;
        repeat (500) begin
            @(negedge clk);
            if (uart.tx_start !== 1'b0) flag = 1'b0;
        end
        chk("busy_hold.tx_start_low", 32'(flag), 32'd1);
        uart.tx_busy = 1'b0;
        @(negedge clk);
        chk("busy_hold.tx_start_rise", 32'(uart.tx_start), 32'd1);
        repeat (5) @(negedge clk);
        chk("busy_hold.tx_start_held", 32'(uart.tx_start), 32'd1);
        serve(3, 2, M_ECHO, 8'h00, model_byte(), sent);
        m_pass++; m_sent++;
        check_model("first_send");

        // Stray byte in GAP; sequence must carry on from 1.
        pulse_rx(8'hAA);
        m_err++; m_last = 8'hAA;
        check_model("stray_gap");
        serve(2, 1, M_ECHO, 8'h00, model_byte(), sent);
        m_pass++; m_sent++;
        check_model("after_gap_stray");

        // Directed vector table.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            serve(vecs[i].busy, vecs[i].lat, vecs[i].mode, 8'h01, vecs[i].exp_tx, sent);
            chk($sformatf("vec%0d.pass", i),    32'(pass_count),    32'(vecs[i].exp_pass));
            chk($sformatf("vec%0d.err", i),     32'(err_count),     32'(vecs[i].exp_err));
            chk($sformatf("vec%0d.timeout", i), 32'(timeout_count), 32'(vecs[i].exp_to));
            chk($sformatf("vec%0d.last", i),    32'(last_err_data), 32'(vecs[i].exp_last));
            chk($sformatf("vec%0d.led_ok", i),  32'(led_ok),        32'(vecs[i].exp_ok));
            chk($sformatf("vec%0d.led_err", i), 32'(led_err),       32'(vecs[i].exp_lerr));
        end

        // Randomized loopback: 300 transactions, wraps the sequence byte.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int         b, l, r, mode;
            logic [7:0] xr;
            b  = int'($urandom_range(1, 30));
            l  = int'($urandom_range(0, 30));
            r  = int'($urandom_range(0, 99));
            xr = 8'($urandom_range(1, 255));
            mode = (r < 3) ? M_NONE : (r < 13) ? M_XOR : M_ECHO;
            serve(b, l, mode, xr, model_byte(), sent);
            if (mode == M_ECHO)     m_pass++;
            else if (mode == M_XOR) begin m_err++; m_last = sent ^ xr; end
            else                    m_to++;
            m_sent++;
            check_model($sformatf("rand%0d", i));
        end

        // Reset while waiting for an echo, then enable held low.
        n = 0;
        while (uart.tx_start !== 1'b1 && n < WAIT_LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("midrst.tx_start_seen", 32'(uart.tx_start), 32'd1);
        sent = uart.tx_data;
        uart.tx_busy = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        uart.tx_busy = 1'b0;
        model_reset();
        chk("midrst.tx_start", 32'(uart.tx_start), 32'd0);
        chk("midrst.tx_data",  32'(uart.tx_data),  32'd0);
        check_model("midrst");
        repeat (10) @(negedge clk);
        pulse_rx(sent);
        m_err++; m_last = sent;
        check_model("late_echo");
        flag = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (uart.tx_start !== 1'b0) flag = 1'b0;
        end
        chk("midrst.stays_idle", 32'(flag), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
